// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch sequencer.
//               Contains the controller state enum, edit_sel digit codes,
//               default prescaler divisors and small state helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_DIR       = 3'd0,
        ST_SET_MIN   = 3'd1,
        ST_SET_TENS  = 3'd2,
        ST_SET_SEC   = 3'd3,
        ST_SET_TENTH = 3'd4,
        ST_RUN       = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Digit codes presented on edit_sel
    localparam logic [1:0] c_sel_min   = 2'd0;
    localparam logic [1:0] c_sel_tens  = 2'd1;
    localparam logic [1:0] c_sel_sec   = 2'd2;
    localparam logic [1:0] c_sel_tenth = 2'd3;

    // 100 MHz clock: 0.1 s count tick, 0.25 s blink half-period
    localparam int c_default_tick_div  = 10_000_000;
    localparam int c_default_blink_div = 25_000_000;
    localparam int c_default_cnt_w     = 25;

    function automatic logic is_set_state(input state_t s);
        return (s == ST_SET_MIN) || (s == ST_SET_TENS) ||
               (s == ST_SET_SEC) || (s == ST_SET_TENTH);
    endfunction

    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] v;
        v = c_sel_min;
        case (s)
            ST_SET_TENS:  v = c_sel_tens;
            ST_SET_SEC:   v = c_sel_sec;
            ST_SET_TENTH: v = c_sel_tenth;
            default:      v = c_sel_min;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_seq_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler counting enabled cycles 0..DIV-1 with synchronous
//               clear (priority over enable) and a one-cycle wrap flag.
// Ports       : clk, rst_n (async active-low), i_clr, i_en -> o_wrap
//               o_wrap is combinational: high in the cycle whose edge takes
//               the count from DIV-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV   = 10,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_wrap = i_en && !i_clr && (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_seq_ctrl
// Description : Single-clock control FSM for the 4-digit stopwatch/timer.
//               Sequences DIR -> SET_MIN -> SET_TENS -> SET_SEC -> SET_TENTH
//               -> RUN -> DONE -> DIR and issues one-cycle command strobes
//               to the digit datapath. All outputs are registered.
// Ports       : in  : clk, rst_n, enter_p, inc_p, dir_p, en, at_limit
//               out : clr, digit_inc, edit_sel[1:0], editing, load_goal,
//                     tick, dir, dash, blank, done
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_seq_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = c_default_tick_div,
    parameter int BLINK_DIV = c_default_blink_div,
    parameter int CNT_W     = c_default_cnt_w
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_p,
    input  logic       inc_p,
    input  logic       dir_p,
    input  logic       en,
    input  logic       at_limit,
    output logic       clr,
    output logic       digit_inc,
    output logic [1:0] edit_sel,
    output logic       editing,
    output logic       load_goal,
    output logic       tick,
    output logic       dir,
    output logic       dash,
    output logic       blank,
    output logic       done
);

    state_t r_state;
    logic   r_init;        // first edge after reset release issues clr
    state_t w_next_set;
    logic   w_set_entry;
    logic   w_run_entry;
    logic   w_tick_en;
    logic   w_tick_wrap;
    logic   w_blink_wrap;

    // Successor of the current SET_* state on enter_p
    always_comb begin
        w_next_set = ST_RUN;
        case (r_state)
            ST_SET_MIN:  w_next_set = ST_SET_TENS;
            ST_SET_TENS: w_next_set = ST_SET_SEC;
            ST_SET_SEC:  w_next_set = ST_SET_TENTH;
            default:     w_next_set = ST_RUN;
        endcase
    end

    assign w_set_entry = !r_init && enter_p &&
                         ((r_state == ST_DIR) ||
                          (is_set_state(r_state) && (r_state != ST_SET_TENTH)));
    assign w_run_entry = !r_init && enter_p && (r_state == ST_SET_TENTH);
    // Pause (en=0) holds the prescaler so the sub-tick phase survives
    assign w_tick_en   = (r_state == ST_RUN) && en && !at_limit;

    tick_gen #(
        .DIV   (TICK_DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_run_entry),
        .i_en   (w_tick_en),
        .o_wrap (w_tick_wrap)
    );

    tick_gen #(
        .DIV   (BLINK_DIV),
        .CNT_W (CNT_W)
    ) u_blink_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_set_entry),
        .i_en   (is_set_state(r_state)),
        .o_wrap (w_blink_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_DIR;
            r_init    <= 1'b1;
            clr       <= 1'b0;
            digit_inc <= 1'b0;
            load_goal <= 1'b0;
            tick      <= 1'b0;
            edit_sel  <= c_sel_min;
            editing   <= 1'b0;
            dir       <= 1'b0;
            dash      <= 1'b1;
            blank     <= 1'b0;
            done      <= 1'b0;
        end else begin
            clr       <= 1'b0;
            digit_inc <= 1'b0;
            load_goal <= 1'b0;
            tick      <= 1'b0;
            if (r_init) begin
                r_init <= 1'b0;
                clr    <= 1'b1;
            end else begin
                case (r_state)
                    ST_DIR: begin
                        if (dir_p) dir <= ~dir;
                        if (enter_p) begin
                            r_state  <= ST_SET_MIN;
                            clr      <= 1'b1;
                            editing  <= 1'b1;
                            edit_sel <= sel_of(ST_SET_MIN);
                            dash     <= 1'b0;
                            blank    <= 1'b0;
                        end
                    end
                    ST_SET_MIN, ST_SET_TENS, ST_SET_SEC, ST_SET_TENTH: begin
                        if (enter_p) begin
                            // enter wins over a same-cycle inc_p
                            r_state <= w_next_set;
                            blank   <= 1'b0;
                            if (w_next_set == ST_RUN) begin
                                editing   <= 1'b0;
                                load_goal <= 1'b1;
                            end else begin
                                edit_sel <= sel_of(w_next_set);
                            end
                        end else begin
                            if (inc_p)        digit_inc <= 1'b1;
                            if (w_blink_wrap) blank     <= ~blank;
                        end
                    end
                    ST_RUN: begin
                        // at_limit also gates the prescaler, so no tick here
                        if (at_limit) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else if (w_tick_wrap) begin
                            tick <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (enter_p) begin
                            r_state <= ST_DIR;
                            done    <= 1'b0;
                            dash    <= 1'b1;
                            clr     <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_DIR;
                        editing <= 1'b0;
                        dash    <= 1'b1;
                        blank   <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_seq_ctrl
// Description : Scoreboard bench for stopwatch_seq_ctrl. The driver applies
//               inputs on the falling clock edge, steps a behavioural model
//               and queues the expected post-edge outputs; a monitor pops and
//               compares after every rising edge and every async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_seq_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;
    localparam int CNT_W     = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enter_p = 1'b0, inc_p = 1'b0, dir_p = 1'b0, en = 1'b0, at_limit = 1'b0;
    logic       clr, digit_inc, editing, load_goal, tick, dir, dash, blank, done;
    logic [1:0] edit_sel;

    stopwatch_seq_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enter_p   (enter_p),
        .inc_p     (inc_p),
        .dir_p     (dir_p),
        .en        (en),
        .at_limit  (at_limit),
        .clr       (clr),
        .digit_inc (digit_inc),
        .edit_sel  (edit_sel),
        .editing   (editing),
        .load_goal (load_goal),
        .tick      (tick),
        .dir       (dir),
        .dash      (dash),
        .blank     (blank),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected vector: {clr, digit_inc, load_goal, tick, editing, edit_sel[1:0], dir, dash, blank, done}
    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    bit   mon_on  = 1'b0;

    // ---------------- behavioural model ----------------
    // phase: 0 dir select, 1..4 editing digit phase-1, 5 running, 6 done
    int m_phase;
    bit m_dir, m_init;
    int m_run_en;     // enabled running cycles since start
    int m_set_cyc;    // cycles spent in current edit phase
    bit p_clr, p_inc, p_load, p_tick;

    function automatic logic [10:0] model_out();
        bit       ed;
        bit [1:0] sel;
        bit       bl;
        ed  = (m_phase >= 1) && (m_phase <= 4);
        sel = ed ? 2'(m_phase - 1) : 2'd0;
        bl  = ed ? (((m_set_cyc / BLINK_DIV) % 2) == 1) : 1'b0;
        return {p_clr, p_inc, p_load, p_tick, ed, sel, m_dir,
                (m_phase == 0), bl, (m_phase == 6)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dir = 0; m_init = 1; m_run_en = 0; m_set_cyc = 0;
        p_clr = 0; p_inc = 0; p_load = 0; p_tick = 0;
    endtask

    task automatic model_step(input bit e, input bit i, input bit d, input bit n, input bit l);
        p_clr = 0; p_inc = 0; p_load = 0; p_tick = 0;
        if (m_init) begin
            m_init = 0;
            p_clr  = 1;
        end else if (m_phase == 0) begin
            if (d) m_dir = !m_dir;
            if (e) begin m_phase = 1; p_clr = 1; m_set_cyc = 0; end
        end else if (m_phase <= 4) begin
            if (e) begin
                if (m_phase == 4) begin m_phase = 5; p_load = 1; m_run_en = 0; end
                else begin m_phase = m_phase + 1; m_set_cyc = 0; end
            end else begin
                m_set_cyc = m_set_cyc + 1;
                if (i) p_inc = 1;
            end
        end else if (m_phase == 5) begin
            if (l) m_phase = 6;
            else if (n) begin
                m_run_en = m_run_en + 1;
                if ((m_run_en % TICK_DIV) == 0) p_tick = 1;
            end
        end else begin
            if (e) begin m_phase = 0; p_clr = 1; end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic push_exp(input string tag);
        exp_t x;
        x.v   = model_out();
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic drive_step(input bit e, input bit i, input bit d, input bit n,
                              input bit l, input string tag);
        enter_p = e; inc_p = i; dir_p = d; en = n; at_limit = l;
        model_step(e, i, d, n, l);
        push_exp(tag);
    endtask

    task automatic step(input bit e, input bit i, input bit d, input bit n,
                        input bit l, input string tag);
        @(negedge clk);
        drive_step(e, i, d, n, l, tag);
    endtask

    // Assert reset between clock edges, hold across one rising edge, release
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        enter_p = 0; inc_p = 0; dir_p = 0; en = 0; at_limit = 0;
        model_reset();
        push_exp(tag);            // checked right after the async assertion
        push_exp({tag, "_hold"}); // next rising edge, reset still low
        mon_on = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        push_exp({tag, "_hold2"});
        @(negedge clk);
        rst_n = 1'b1;
        drive_step(0, 0, 0, 0, 0, {tag, "_release"});
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (mon_on) begin
                #1;
                n_total++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL queue_empty t=%0t got=no_expectation required=expectation", $time);
                end else begin
                    exp_t        x;
                    logic [10:0] got;
                    x   = q.pop_front();
                    got = {clr, digit_inc, load_goal, tick, editing, edit_sel,
                           dir, dash, blank, done};
                    if (!x.v[6]) got[5:4] = x.v[5:4];  // edit_sel don't-care outside edit
                    if (got !== x.v) begin
                        n_bad++;
                        $display("FAIL %s t=%0t got=%b required=%b", x.tag, $time, got, x.v);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        async_reset("reset");
        step(0, 0, 0, 0, 0, "dir_idle");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0, "dir_toggle");
            step(0, 0, 0, 0, 0, "dir_hold");
        end
        step(1, 0, 0, 0, 0, "enter_set_min");
        step(0, 0, 1, 0, 0, "dirp_in_set");
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0, "blink_min");
        step(1, 0, 0, 0, 0, "enter_set_tens");
        step(1, 1, 0, 0, 0, "enter_inc_tens");
        step(0, 1, 0, 0, 0, "inc_sec_a");
        step(0, 0, 0, 0, 0, "sec_idle");
        step(0, 1, 0, 0, 0, "inc_sec_b");
        step(1, 0, 0, 0, 0, "enter_set_tenth");
        step(1, 0, 0, 1, 0, "enter_run");
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0, "run_count");
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, "run_pause");
        for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 0, "run_resume");
        step(1, 0, 0, 1, 0, "enter_in_run");
        for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 0, "run_count2");
        step(0, 0, 0, 1, 1, "limit_on_wrap");
        step(0, 0, 0, 1, 0, "done_hold");
        step(1, 0, 0, 0, 0, "done_to_dir");
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, "walk_to_run");
        step(1, 0, 0, 1, 0, "enter_run2");
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0, "run2");
        async_reset("reset_mid_run");
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, "random");
        end
        @(negedge clk);
        #2;
        n_total++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got=%0d pending required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_seq_ctrl.md
Name: stopwatch_seq_ctrl

Overview:
- Control FSM that sequences the 4-digit stopwatch/timer datapath (min, 10 s, 1 s, 0.1 s registers) on a single clock.
- Replaces the ad-hoc button-clocked always blocks with one clocked controller.
- Inputs: already debounced and one-pulsed button events, plus the enable switch.
- Outputs: per-cycle command strobes to the digit datapath (clear, increment selected digit, latch goal, count tick), plus direction and status.

Parameters:
TICK_DIV, 10_000_000, clk cycles per 0.1 s count tick (100 MHz clk)
BLINK_DIV, 25_000_000, clk cycles per blink half-period of the digit being edited
CNT_W, 25, width of prescaler counters; must hold max(TICK_DIV, BLINK_DIV)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enter_p  in  1  one-cycle pulse, enter button
inc_p  in  1  one-cycle pulse, input_number button
dir_p  in  1  one-cycle pulse, count_down button
en  in  1  level, start(1)/pause(0) switch, already synchronous
at_limit  in  1  datapath flag: time == goal (count-up) or 0:00.0 (count-down)
clr  out  1  one-cycle pulse: datapath zeroes all digits
digit_inc  out  1  one-cycle pulse: increment (with wrap) digit edit_sel
edit_sel  out  2  0=min, 1=10 s, 2=1 s, 3=0.1 s; valid only when editing=1
editing  out  1  high in SET_* states
load_goal  out  1  one-cycle pulse: datapath latches goal = (dir ? 0 : current time)
tick  out  1  one-cycle pulse: datapath steps one 0.1 s in direction dir
dir  out  1  0 = count up, 1 = count down; also drives led0
dash  out  1  high in DIR state: display shows "----"
blank  out  1  blink mask for the edited digit; 0 when not editing
done  out  1  high in DONE state

Behaviour:
- Reset (rst_n low, async): state=DIR, dir=0; prescalers cleared; all pulses 0, blank=0, done=0.
  - clr asserts for one cycle on the first clk edge after reset release.
- States: DIR -> SET_MIN -> SET_TENS -> SET_SEC -> SET_TENTH -> RUN -> DONE -> DIR.
  - Each arrow except RUN->DONE is taken on enter_p; RUN->DONE is taken on at_limit.
- DIR: dash=1. dir_p toggles dir the same edge. dir_p is ignored in every other state.
  - enter_p: go to SET_MIN, assert clr for one cycle.
- SET_*: editing=1, edit_sel = 0,1,2,3 respectively.
  - inc_p: digit_inc=1 next cycle. Wrap (1/5/9/9) is owned by the datapath.
  - Same cycle enter_p and inc_p: enter wins, no digit_inc.
- SET_TENTH + enter_p: go to RUN, load_goal=1 for one cycle, tick prescaler cleared to 0.
- RUN tick prescaler:
  - Increments only while en=1 and at_limit=0; holds its value while en=0 (pause keeps the sub-tick phase).
  - tick=1 in the cycle the count wraps TICK_DIV-1 -> 0.
  - First tick fires exactly TICK_DIV enabled cycles after RUN entry.
- RUN with at_limit=1 (including at entry, e.g. count-down from 0:00.0): no tick; go to DONE next edge.
  - If a wrap coincides with at_limit, the tick is suppressed.
- DONE: done=1, no ticks, time held. enter_p: go to DIR, clr=1 for one cycle, dir kept.
- enter_p in RUN: ignored.
- blank: BLINK_DIV prescaler free-runs in SET_* and is cleared on every SET state entry.
  - blank toggles at each wrap and starts 0 on entry; forced 0 outside SET_*.
- All outputs registered. Command pulses are one cycle and mutually exclusive.
- Reset mid-RUN aborts immediately to DIR. Datapath shares rst_n.

Decomposition:
- Shared package stopwatch_pkg: state enum (DIR, SET_MIN, SET_TENS, SET_SEC, SET_TENTH, RUN, DONE), edit_sel digit encodings, default TICK_DIV/BLINK_DIV.
- One sub-module: tick_gen (parameterised prescaler with clear, enable, one-cycle wrap pulse). Instantiate twice, for tick and blink.
- FSM stays in stopwatch_seq_ctrl.

Test Plan:
- Reset release: clr pulse on cycle 1, dir=0, dash=1; dir_p x3 -> dir=1.
  - enter_p -> editing=1, edit_sel=0, clr pulse.
- TICK_DIV=4: walk SET_* with inc_p x2 in SET_SEC, enter_p x4.
  - Expect two digit_inc with edit_sel=2, then load_goal, then tick on every 4th cycle with en=1.
- Pause: en=0 after 2 enabled cycles of a tick period for 10 cycles, then en=1 -> next tick exactly 2 cycles after resume.
- at_limit asserted on a wrap cycle -> no tick that cycle, done=1 next cycle.
  - enter_p -> DIR, clr pulse, dir unchanged.
- Same-cycle enter_p+inc_p in SET_TENS -> edit_sel=2, no digit_inc.
  - dir_p in SET_MIN -> dir unchanged.
- rst_n low asynchronously mid-RUN (between clk edges) -> state DIR, tick=0, blank=0 immediately.
  - BLINK_DIV=3 in SET_MIN -> blank toggles every 3 cycles.
